// File: rtl/trace_fifo_pkg.sv
// Shared definitions for the trace packet FIFO: packet width and overflow marker layout.
package trace_fifo_pkg;

  localparam int          PKT_W   = 32;
  localparam int          CNT_W   = 16;
  localparam logic [15:0] OVF_TAG = 16'hFFFE;

  // Marker word: reserved tag in the upper half, dropped-packet count in the lower half.
  typedef struct packed {
    logic [15:0]      tag;
    logic [CNT_W-1:0] cnt;
  } marker_t;

  function automatic logic [PKT_W-1:0] make_marker(input logic [CNT_W-1:0] cnt);
    marker_t m;
    m.tag = OVF_TAG;
    m.cnt = cnt;
    return m;
  endfunction

endpackage

// File: rtl/trace_fifo_ram.sv
// Simple dual-port packet RAM: one write port, one registered read port.
module trace_fifo_ram
  import trace_fifo_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PKT_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [PKT_W-1:0]  o_rdata
);

  logic [PKT_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/trace_fifo.sv
// Elastic trace packet buffer: drops whole packets on overflow and later inserts
// a marker word carrying the number of packets lost.
module trace_fifo
  import trace_fifo_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int ADDR_W       = 9,
  parameter int RESUME_LEVEL = 256
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [PKT_W-1:0]  in_data,
  input  logic              in_strobe,
  output logic [PKT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              ovf_active
);

  localparam logic [ADDR_W:0] L_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_RESUME = (ADDR_W+1)'(RESUME_LEVEL);
  localparam logic [ADDR_W:0] L_ONE    = (ADDR_W+1)'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_stage_vld;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_pop;
  logic              w_full;
  logic              w_marker;
  logic              w_push;
  logic              w_we;
  logic              w_arr_nempty;
  logic              w_stage_take;
  logic              w_rd_en;
  logic [CNT_W-1:0]  w_cnt;
  logic [PKT_W-1:0]  w_wr_data;
  logic [PKT_W-1:0]  w_ram_rdata;

  // Decisions use the registered level, so a same-cycle pop never frees space for a push.
  assign w_pop        = out_valid && out_ready;
  assign w_full       = (level == L_DEPTH);
  assign w_marker     = ovf_active && (level <= L_RESUME);
  assign w_push       = in_strobe && !ovf_active && !w_full;
  assign w_we         = (w_push || w_marker) && !clear;
  assign w_cnt        = sat_inc(r_drop_cnt, in_strobe);
  assign w_wr_data    = w_marker ? make_marker(w_cnt) : in_data;

  // Read stage is refilled whenever it is empty or being handed to the output register.
  assign w_arr_nempty = (r_wr_ptr != r_rd_ptr);
  assign w_stage_take = r_stage_vld && (!out_valid || w_pop);
  assign w_rd_en      = w_arr_nempty && (!r_stage_vld || w_stage_take);

  trace_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (mclk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (w_wr_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_stage_vld <= 1'b0;
      r_drop_cnt  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      level       <= '0;
      ovf_active  <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_stage_vld <= 1'b0;
      r_drop_cnt  <= '0;
      out_valid   <= 1'b0;
      level       <= '0;
      ovf_active  <= 1'b0;
    end else begin
      if (w_we)    r_wr_ptr <= r_wr_ptr + L_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + L_ONE;

      if (w_rd_en)           r_stage_vld <= 1'b1;
      else if (w_stage_take) r_stage_vld <= 1'b0;

      if (w_stage_take) begin
        out_valid <= 1'b1;
        out_data  <= w_ram_rdata;
      end else if (w_pop) begin
        out_valid <= 1'b0;
      end

      level <= level + (w_we ? L_ONE : '0) - (w_pop ? L_ONE : '0);

      // Drop bookkeeping: marker closes the episode, otherwise count or enter drop mode.
      if (w_marker) begin
        ovf_active <= 1'b0;
        r_drop_cnt <= '0;
      end else if (in_strobe && ovf_active) begin
        r_drop_cnt <= sat_inc(r_drop_cnt, 1'b1);
      end else if (in_strobe && w_full) begin
        ovf_active <= 1'b1;
        r_drop_cnt <= CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/trace_fifo.md
Name: trace_fifo

Overview:
- Elastic buffer between the tracing state machine's 32-bit packet output (packet_data/packet_strobe) and the USB FIFO writer.
- The trace side can emit one packet per mclk; the USB side drains far slower. The block absorbs bursts.
- On overflow it drops whole packets, then inserts one overflow marker packet carrying the drop count, so the host can detect gaps and resynchronise timestamps.

Parameters:
- DEPTH, 512, total packet capacity (array plus output register); must be a power of 2, at least 4.
- ADDR_W, 9, log2(DEPTH).
- RESUME_LEVEL, 256, after an overflow, occupancy at or below which the marker is written and acceptance resumes; must be less than DEPTH.

Ports:
- mclk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush.
- in_data  input  32  packet word from usb_packet_assemble.
- in_strobe  input  1  in_data valid this cycle. There is no backpressure; a packet that is not accepted is dropped.
- out_data  output  32  head packet, registered.
- out_valid  output  1  out_data holds a packet.
- out_ready  input  1  consumer takes the packet when out_valid and out_ready are both high at an edge.
- level  output  ADDR_W+1  packets held, range 0..DEPTH.
- ovf_active  output  1  overflow in progress (drop mode).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, level=0, ovf_active=0; internal drop_count=0; pointers=0.
- Ordering: strict FIFO order is preserved. The marker occupies a normal slot in the sequence.
- Push accept rule: packet written iff in_strobe && !ovf_active && level<DEPTH, with level taken as the registered value. A pop in the same cycle does not free space for that push.
- Entering drop mode: in_strobe with level==DEPTH and !ovf_active sets ovf_active=1 and drop_count=1.
- While ovf_active=1:
  - every in_strobe is dropped and increments drop_count, saturating at 16'hFFFF;
  - no data is written even if space exists, until level<=RESUME_LEVEL.
- Marker cycle: the first cycle with ovf_active && level<=RESUME_LEVEL.
  - Writes {OVF_TAG, cnt}. cnt = drop_count + in_strobe, saturating at 16'hFFFF.
  - A coincident in_strobe packet is dropped but is counted in that marker.
  - ovf_active clears at this edge; drop_count returns to 0.
  - Normal acceptance resumes the next cycle.
- Latency: packet accepted at edge k into an empty FIFO gives out_valid=1 after edge k+2. This is one cycle for the synchronous RAM read plus one for the output register.
- Output register:
  - out_data and out_valid change only when out_valid=0 or a pop occurs.
  - With back-to-back data available, sustains one pop per cycle (prefetch through the RAM read stage).
- level: +1 on accepted write (including marker), -1 on pop; both in one cycle leaves it unchanged. level counts array, read stage and output register.
- Pointer wrap: ADDR_W-bit RAM index plus wrap bit; wraps modulo DEPTH with no gap.
- clear: priority over push, pop and marker. Next cycle: level=0, out_valid=0, ovf_active=0, drop_count=0. RAM contents are don't-care.
- Reset mid-operation: all state returns to reset values immediately; no packet or marker is emitted afterwards.
- out_data while out_valid=0: holds its last value. The consumer must not sample it.

Decomposition:
- Shared include trace_defs.vh:
  - OVF_TAG = 16'hFFFE, upper half of the marker word. This encoding is reserved and never produced by usb_packet_assemble.
  - Packet width = 32.
  - Marker field positions.
- Sub-module trace_fifo_ram: simple dual-port RAM, DEPTH x 32, one write port, one synchronous read port, inferred block RAM.
- Pointer, level, drop and marker logic and the output register stay in trace_fifo.

Test Plan:
All scenarios use DEPTH=8, ADDR_W=3, RESUME_LEVEL=4.
1. Reset, then push 0x11111111 at edge 0 with out_ready=1 -> out_valid=1 with out_data=0x11111111 after edge 2; level back to 0 after the pop.
2. Push 12 consecutive words 0..11 with out_ready=0 -> words 0..7 stored; level=8; ovf_active=1 from word 8; drop_count=4.
3. Continuing from 2, raise out_ready until level=4, no input -> marker 0xFFFE0004 is written behind word 7; drain yields 0..7, then 0xFFFE0004; ovf_active=0.
4. Same as 3, but in_strobe high on the marker cycle -> marker=0xFFFE0005; the next pushed word follows the marker.
5. Simultaneous push and pop at level=8 -> push dropped, ovf_active=1, level=7. Simultaneous push and pop at level=3 -> level stays 3, order preserved.
6. Assert clear at level=5 with ovf_active=1 -> next cycle level=0, out_valid=0, ovf_active=0. Assert reset_n=0 mid-burst -> outputs 0 immediately.
